// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: processor-wide default widths, the reset
// fetch address, queue operation encoding and the saturating counter helper
// used by the optional performance counters (FETCH_PERF_CNT_EN).
package fetch_unit_pkg;

    // Processor-wide defaults, kept next to the instruction constants.
    localparam int unsigned PC_WIDTH_DEF    = 16;
    localparam int unsigned INSTR_WIDTH_DEF = 32;
    localparam int unsigned PC_INITIAL_DEF  = 0;
    localparam int unsigned QUEUE_DEPTH_DEF = 4;

    // Width of each performance counter.
    localparam int unsigned PERF_CNT_WIDTH  = 16;

    // What the prefetch queue does in a given cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        Q_IDLE = 2'b00,
        Q_POP  = 2'b01,
        Q_PUSH = 2'b10,
        Q_BOTH = 2'b11
    } queueOp_e;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [PERF_CNT_WIDTH-1:0] satIncr(
        input logic [PERF_CNT_WIDTH-1:0] value
    );
        if (value == {PERF_CNT_WIDTH{1'b1}}) begin
            return value;
        end
        return value + PERF_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO for the fetch stage. The entry at the head is presented
// combinationally. A flush empties the queue and overrides any push in the
// same cycle. Storage is cleared on reset so the head reads as zero until the
// first instruction arrives.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = QUEUE_DEPTH_DEF,
    parameter int unsigned WIDTH = INSTR_WIDTH_DEF + PC_WIDTH_DEF,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_in,
    input  logic             RST,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;

    logic             w_pushEff;
    logic             w_popEff;
    queueOp_e         w_op;

    // Qualify push/pop: flush cancels both, pop needs data, push needs room
    // (a slot freed by a simultaneous pop counts as room).
    always_comb begin
        w_popEff  = i_pop & (r_count != '0) & ~i_flush;
        w_pushEff = i_push & ~i_flush & ((r_count != CW'(DEPTH)) | w_popEff);
        w_op      = queueOp_e'({w_pushEff, w_popEff});
    end

    // Entry storage; written at the tail on every accepted push.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_pushEff) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            unique case (w_op)
                Q_PUSH: begin
                    r_wrPtr <= r_wrPtr + AW'(1);
                    r_count <= r_count + CW'(1);
                end
                Q_POP: begin
                    r_rdPtr <= r_rdPtr + AW'(1);
                    r_count <= r_count - CW'(1);
                end
                Q_BOTH: begin
                    r_wrPtr <= r_wrPtr + AW'(1);
                    r_rdPtr <= r_rdPtr + AW'(1);
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // Head entry and status straight from the registers.
    always_comb begin
        o_head  = r_mem[r_rdPtr];
        o_count = r_count;
        o_empty = (r_count == '0);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with a prefetch queue and a valid/ready output.
// Drives the read port of a synchronous program memory (data returns the cycle
// after the strobe), buffers {instr, pc+1} pairs in fetch_queue, and restarts at
// pc_in on a redirect, discarding queued and in-flight instructions.
// Optional: define FETCH_PERF_CNT_EN to add saturating stall_cnt / flush_cnt outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int unsigned PC_INITIAL  = PC_INITIAL_DEF,
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   pc_chg,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic                   mem_rd,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]            stall_cnt,
    output logic [15:0]            flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned RW = CW + 1;
    localparam int unsigned EW = INSTR_WIDTH + PC_WIDTH;
    localparam logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(PC_INITIAL);

    logic [PC_WIDTH-1:0] r_fetchPc;
    logic                r_inflight;
    logic [PC_WIDTH-1:0] r_inflightPc;

    logic [CW-1:0]       w_count;
    logic                w_empty;
    logic [EW-1:0]       w_head;
    logic [EW-1:0]       w_pushData;
    logic [RW-1:0]       w_reserved;
    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;

    // Handshake and issue decisions. A read is only issued if a queue slot is
    // guaranteed for its data, counting the read already in flight and any
    // entry leaving this cycle. The read strobe is held low while in reset.
    always_comb begin
        w_valid    = ~w_empty & ~pc_chg;
        w_pop      = w_valid & out_ready;
        w_push     = r_inflight & ~pc_chg;
        w_reserved = RW'(w_count) + RW'(r_inflight) - RW'(w_pop);
        w_issue    = RST & ~pc_chg & (w_reserved < RW'(QUEUE_DEPTH));
        w_pushData = {mem_data, r_inflightPc + PC_WIDTH'(1)};
    end

    // Fetch address and in-flight tracking; a redirect drops the pending read.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            r_fetchPc    <= PC_RESET;
            r_inflight   <= 1'b0;
            r_inflightPc <= PC_RESET;
        end else if (pc_chg) begin
            r_fetchPc    <= pc_in;
            r_inflight   <= 1'b0;
        end else if (w_issue) begin
            r_fetchPc    <= r_fetchPc + PC_WIDTH'(1);
            r_inflight   <= 1'b1;
            r_inflightPc <= r_fetchPc;
        end else begin
            r_inflight   <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk_in  (clk_in),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (pc_chg),
        .i_data  (w_pushData),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Memory port and decode-facing outputs.
    always_comb begin
        mem_rd    = w_issue;
        mem_addr  = r_fetchPc;
        out_valid = w_valid;
        instr     = w_head[EW-1:PC_WIDTH];
        pc_out    = w_head[PC_WIDTH-1:0];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] r_stallCnt;
    logic [PERF_CNT_WIDTH-1:0] r_flushCnt;

    // Count cycles with nothing offered to decode and cycles spent redirecting.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!w_valid) begin
                r_stallCnt <= satIncr(r_stallCnt);
            end
            if (pc_chg) begin
                r_flushCnt <= satIncr(r_flushCnt);
            end
        end
    end

    // Expose the counters.
    always_comb begin
        stall_cnt = r_stallCnt;
        flush_cnt = r_flushCnt;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Two instances share clock and reset: one
// with default parameters, one starting at 16'hFFFE for the wrap-around case.
// Each has a synchronous memory model returning word[a] = a.
// Perf-counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

    logic        clk_in = 1'b0;
    logic        RST;
    logic        pc_chg;
    logic [15:0] pc_in;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [15:0] pc_out;

    logic        pc_chg2 = 1'b0;
    logic [15:0] pc_in2 = '0;
    logic        mem_rd2;
    logic [15:0] mem_addr2;
    logic [31:0] mem_data2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] instr2;
    logic [15:0] pc_out2;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] stall_cnt2;
    logic [15:0] flush_cnt2;
`endif

    int numChecks   = 0;
    int numFailures = 0;

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    // Synchronous program memories: word[a] = a.
    always @(posedge clk_in) begin
        if (mem_rd) mem_data <= 32'(mem_addr);
        if (mem_rd2) mem_data2 <= 32'(mem_addr2);
    end

    fetch_unit dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .pc_chg    (pc_chg),
        .pc_in     (pc_in),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .pc_out    (pc_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    fetch_unit #(.PC_INITIAL(16'hFFFE)) dutWrap (
        .clk_in    (clk_in),
        .RST       (RST),
        .pc_chg    (pc_chg2),
        .pc_in     (pc_in2),
        .mem_rd    (mem_rd2),
        .mem_addr  (mem_addr2),
        .mem_data  (mem_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .instr     (instr2),
        .pc_out    (pc_out2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt2),
        .flush_cnt (flush_cnt2)
`endif
    );

    // Advance one clock and settle 2 time units past the edge.
    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    // Pulse reset for one edge and release it mid-cycle; returns in cycle 0.
    task automatic doReset();
        @(posedge clk_in);
        #1;
        RST       = 1'b0;
        pc_chg    = 1'b0;
        pc_in     = '0;
        out_ready = 1'b0;
        @(posedge clk_in);
        #1;
        RST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk_in);
        #3;
        RST = 1'b0;
        pc_chg = 1'b0;
        out_ready = 1'b1;
        #1;
        numChecks++; if (out_valid !== 1'b0) begin numFailures++; $display("[TB] FAIL reset_valid: got %0h expected 0", out_valid); end
        numChecks++; if (mem_rd !== 1'b0) begin numFailures++; $display("[TB] FAIL reset_mem_rd: got %0h expected 0", mem_rd); end
        numChecks++; if (mem_addr !== 16'h0000) begin numFailures++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        numChecks++; if (instr !== 32'h0) begin numFailures++; $display("[TB] FAIL reset_instr: got %0h expected 0", instr); end
        numChecks++; if (pc_out !== 16'h0) begin numFailures++; $display("[TB] FAIL reset_pc_out: got %0h expected 0", pc_out); end
        numChecks++; if (mem_addr2 !== 16'hFFFE) begin numFailures++; $display("[TB] FAIL reset_mem_addr_wrap: got %0h expected fffe", mem_addr2); end
`ifdef FETCH_PERF_CNT_EN
        numChecks++; if (stall_cnt !== 16'h0) begin numFailures++; $display("[TB] FAIL reset_stall_cnt: got %0h expected 0", stall_cnt); end
        numChecks++; if (flush_cnt !== 16'h0) begin numFailures++; $display("[TB] FAIL reset_flush_cnt: got %0h expected 0", flush_cnt); end
`endif
        @(posedge clk_in);
        #1;
        RST = 1'b1;
        #1;
        numChecks++; if (mem_rd !== 1'b1) begin numFailures++; $display("[TB] FAIL release_mem_rd: got %0h expected 1", mem_rd); end
        numChecks++; if (mem_addr !== 16'h0000) begin numFailures++; $display("[TB] FAIL release_mem_addr: got %0h expected 0", mem_addr); end
    endtask

    task automatic test_stream();
        doReset();
        out_ready = 1'b1;
        #1;
        numChecks++; if (out_valid !== 1'b0) begin numFailures++; $display("[TB] FAIL stream_valid_c0: got %0h expected 0", out_valid); end
        step();
        numChecks++; if (out_valid !== 1'b0) begin numFailures++; $display("[TB] FAIL stream_valid_c1: got %0h expected 0", out_valid); end
        step();
        for (int k = 0; k < 8; k++) begin
            numChecks++; if (out_valid !== 1'b1) begin numFailures++; $display("[TB] FAIL stream_valid[%0d]: got %0h expected 1", k, out_valid); end
            numChecks++; if (instr !== 32'(k)) begin numFailures++; $display("[TB] FAIL stream_instr[%0d]: got %0h expected %0h", k, instr, k); end
            numChecks++; if (pc_out !== 16'(k + 1)) begin numFailures++; $display("[TB] FAIL stream_pc_out[%0d]: got %0h expected %0h", k, pc_out, k + 1); end
            step();
        end
    endtask

    task automatic test_back_pressure();
        doReset();
        out_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            numChecks++; if (out_valid !== 1'b1) begin numFailures++; $display("[TB] FAIL hold_valid[%0d]: got %0h expected 1", i, out_valid); end
            numChecks++; if (instr !== 32'h0) begin numFailures++; $display("[TB] FAIL hold_instr[%0d]: got %0h expected 0", i, instr); end
            numChecks++; if (pc_out !== 16'h1) begin numFailures++; $display("[TB] FAIL hold_pc_out[%0d]: got %0h expected 1", i, pc_out); end
            step();
        end
        numChecks++; if (mem_rd !== 1'b0) begin numFailures++; $display("[TB] FAIL full_mem_rd: got %0h expected 0", mem_rd); end
        out_ready = 1'b1;
        #1;
        numChecks++; if (mem_rd !== 1'b1) begin numFailures++; $display("[TB] FAIL drain_mem_rd: got %0h expected 1", mem_rd); end
        numChecks++; if (mem_addr !== 16'h0004) begin numFailures++; $display("[TB] FAIL drain_mem_addr: got %0h expected 4", mem_addr); end
        for (int k = 0; k < 6; k++) begin
            numChecks++; if (out_valid !== 1'b1) begin numFailures++; $display("[TB] FAIL drain_valid[%0d]: got %0h expected 1", k, out_valid); end
            numChecks++; if (instr !== 32'(k)) begin numFailures++; $display("[TB] FAIL drain_instr[%0d]: got %0h expected %0h", k, instr, k); end
            numChecks++; if (pc_out !== 16'(k + 1)) begin numFailures++; $display("[TB] FAIL drain_pc_out[%0d]: got %0h expected %0h", k, pc_out, k + 1); end
            step();
        end
    endtask

    task automatic test_redirect();
        doReset();
        out_ready = 1'b0;
        repeat (4) step();
        numChecks++; if (instr !== 32'h0) begin numFailures++; $display("[TB] FAIL pre_redirect_instr: got %0h expected 0", instr); end
        pc_chg = 1'b1;
        pc_in  = 16'h0040;
        #1;
        numChecks++; if (out_valid !== 1'b0) begin numFailures++; $display("[TB] FAIL redirect_valid: got %0h expected 0", out_valid); end
        numChecks++; if (mem_rd !== 1'b0) begin numFailures++; $display("[TB] FAIL redirect_mem_rd: got %0h expected 0", mem_rd); end
        step();
        pc_chg = 1'b0;
        out_ready = 1'b1;
        #1;
        numChecks++; if (out_valid !== 1'b0) begin numFailures++; $display("[TB] FAIL redirect_valid_c1: got %0h expected 0", out_valid); end
        numChecks++; if (mem_rd !== 1'b1) begin numFailures++; $display("[TB] FAIL redirect_issue: got %0h expected 1", mem_rd); end
        numChecks++; if (mem_addr !== 16'h0040) begin numFailures++; $display("[TB] FAIL redirect_mem_addr: got %0h expected 40", mem_addr); end
        step();
        numChecks++; if (out_valid !== 1'b0) begin numFailures++; $display("[TB] FAIL redirect_valid_c2: got %0h expected 0", out_valid); end
        step();
        numChecks++; if (out_valid !== 1'b1) begin numFailures++; $display("[TB] FAIL redirect_valid_c3: got %0h expected 1", out_valid); end
        numChecks++; if (instr !== 32'h40) begin numFailures++; $display("[TB] FAIL redirect_instr: got %0h expected 40", instr); end
        numChecks++; if (pc_out !== 16'h41) begin numFailures++; $display("[TB] FAIL redirect_pc_out: got %0h expected 41", pc_out); end
        step();
        numChecks++; if (instr !== 32'h41) begin numFailures++; $display("[TB] FAIL redirect_next_instr: got %0h expected 41", instr); end
        numChecks++; if (pc_out !== 16'h42) begin numFailures++; $display("[TB] FAIL redirect_next_pc_out: got %0h expected 42", pc_out); end
    endtask

    task automatic test_wrap();
        doReset();
        numChecks++; if (mem_rd2 !== 1'b1) begin numFailures++; $display("[TB] FAIL wrap_mem_rd: got %0h expected 1", mem_rd2); end
        numChecks++; if (mem_addr2 !== 16'hFFFE) begin numFailures++; $display("[TB] FAIL wrap_addr_c0: got %0h expected fffe", mem_addr2); end
        step();
        numChecks++; if (mem_addr2 !== 16'hFFFF) begin numFailures++; $display("[TB] FAIL wrap_addr_c1: got %0h expected ffff", mem_addr2); end
        step();
        numChecks++; if (mem_addr2 !== 16'h0000) begin numFailures++; $display("[TB] FAIL wrap_addr_c2: got %0h expected 0", mem_addr2); end
        numChecks++; if (out_valid2 !== 1'b1) begin numFailures++; $display("[TB] FAIL wrap_valid: got %0h expected 1", out_valid2); end
        numChecks++; if (instr2 !== 32'hFFFE) begin numFailures++; $display("[TB] FAIL wrap_instr0: got %0h expected fffe", instr2); end
        numChecks++; if (pc_out2 !== 16'hFFFF) begin numFailures++; $display("[TB] FAIL wrap_pc_out0: got %0h expected ffff", pc_out2); end
        step();
        numChecks++; if (instr2 !== 32'hFFFF) begin numFailures++; $display("[TB] FAIL wrap_instr1: got %0h expected ffff", instr2); end
        numChecks++; if (pc_out2 !== 16'h0000) begin numFailures++; $display("[TB] FAIL wrap_pc_out1: got %0h expected 0", pc_out2); end
        step();
        numChecks++; if (instr2 !== 32'h0) begin numFailures++; $display("[TB] FAIL wrap_instr2: got %0h expected 0", instr2); end
        numChecks++; if (pc_out2 !== 16'h0001) begin numFailures++; $display("[TB] FAIL wrap_pc_out2: got %0h expected 1", pc_out2); end
    endtask

    task automatic test_async_reset();
        doReset();
        out_ready = 1'b1;
        repeat (5) step();
        numChecks++; if (instr !== 32'h3) begin numFailures++; $display("[TB] FAIL midstream_instr: got %0h expected 3", instr); end
        #2;
        RST = 1'b0;
        #1;
        numChecks++; if (out_valid !== 1'b0) begin numFailures++; $display("[TB] FAIL async_valid: got %0h expected 0", out_valid); end
        numChecks++; if (mem_rd !== 1'b0) begin numFailures++; $display("[TB] FAIL async_mem_rd: got %0h expected 0", mem_rd); end
        numChecks++; if (mem_addr !== 16'h0) begin numFailures++; $display("[TB] FAIL async_mem_addr: got %0h expected 0", mem_addr); end
        numChecks++; if (instr !== 32'h0) begin numFailures++; $display("[TB] FAIL async_instr: got %0h expected 0", instr); end
        numChecks++; if (pc_out !== 16'h0) begin numFailures++; $display("[TB] FAIL async_pc_out: got %0h expected 0", pc_out); end
        @(posedge clk_in);
        #1;
        RST = 1'b1;
        #1;
        numChecks++; if (mem_rd !== 1'b1) begin numFailures++; $display("[TB] FAIL restart_mem_rd: got %0h expected 1", mem_rd); end
        numChecks++; if (mem_addr !== 16'h0) begin numFailures++; $display("[TB] FAIL restart_mem_addr: got %0h expected 0", mem_addr); end
        step();
        step();
        numChecks++; if (out_valid !== 1'b1) begin numFailures++; $display("[TB] FAIL restart_valid: got %0h expected 1", out_valid); end
        numChecks++; if (instr !== 32'h0) begin numFailures++; $display("[TB] FAIL restart_instr: got %0h expected 0", instr); end
        numChecks++; if (pc_out !== 16'h1) begin numFailures++; $display("[TB] FAIL restart_pc_out: got %0h expected 1", pc_out); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        doReset();
        out_ready = 1'b1;
        step();
        step();
        numChecks++; if (stall_cnt !== 16'd2) begin numFailures++; $display("[TB] FAIL perf_startup_stall: got %0d expected 2", stall_cnt); end
        for (int r = 0; r < 3; r++) begin
            pc_chg = 1'b1;
            pc_in  = 16'h0010;
            step();
            pc_chg = 1'b0;
            step();
            step();
            numChecks++; if (out_valid !== 1'b1) begin numFailures++; $display("[TB] FAIL perf_refill_valid[%0d]: got %0h expected 1", r, out_valid); end
        end
        numChecks++; if (flush_cnt !== 16'd3) begin numFailures++; $display("[TB] FAIL perf_flush_cnt: got %0d expected 3", flush_cnt); end
        numChecks++; if (stall_cnt !== 16'd11) begin numFailures++; $display("[TB] FAIL perf_stall_cnt: got %0d expected 11", stall_cnt); end
    endtask
`endif

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        RST       = 1'b0;
        pc_chg    = 1'b0;
        pc_in     = '0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFailures);
        $finish;
    end

endmodule
